// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM states, frame geometry,
// FIFO depth and the default timing parameters.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int FRAME_BITS      = 8;
  localparam int FIFO_DEPTH      = 4;
  localparam int FILTER_LEN_DEF  = 8;
  localparam int TIMEOUT_CYC_DEF = 16384;
  localparam int HOLDOFF_DEF     = 4;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [FRAME_BITS-1:0] data,
                                         input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Synchronizes the PS/2 lines into mclk, removes short glitches from the
// PS/2 clock and flags each accepted falling edge with a one-cycle strobe.
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic mclk,
  input  logic reset_in,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt;
  logic          filt_prev;
  logic [CW-1:0] run_cnt;

  // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1.
  always_ff @(posedge mclk) begin
    if (reset_in) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Accept a new clock level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge mclk) begin
    if (reset_in) begin
      filt      <= 1'b1;
      filt_prev <= 1'b1;
      run_cnt   <= '0;
    end else begin
      filt_prev <= filt;
      if (clk_sync[1] == filt) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        filt    <= clk_sync[1];
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

  assign data_sync = dat_sync[1];
  assign fall      = filt_prev & ~filt;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: frame decoding FSM, 4-entry byte FIFO and a
// presentation stage with read holdoff.
//
// Consumer handshake: Scan_DAV is the valid, DoRead is the acknowledge.
// A byte is transferred in a cycle where Scan_DAV=1 and DoRead=1; Scan_DAV
// drops the next cycle and the next byte cannot appear for HOLDOFF cycles.
// DoRead with Scan_DAV=0 has no effect. Scan_Code stays stable until the
// next presentation, so it may be read after the acknowledge.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int HOLDOFF     = HOLDOFF_DEF
) (
  input  logic       mclk,
  input  logic       reset_in,
  input  logic       PS2_Clk,
  input  logic       PS2_Data,
  input  logic       DoRead,
  output logic       Scan_DAV,
  output logic [7:0] Scan_Code,
  output logic       Scan_Err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int HW = $clog2(HOLDOFF + 2);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  // Filtered PS/2 interface
  logic ps2_fall;
  logic ps2_data_s;

  // Frame decoder state
  ps2_state_t            state;
  logic [2:0]            bitcnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  par_bit;
  logic [TW-1:0]         tmo_cnt;
  logic                  push_valid;
  logic [FRAME_BITS-1:0] push_data;
  logic                  err_req;

  // FIFO and presentation state
  logic [FRAME_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [NW-1:0]         count;
  logic [HW-1:0]         holdoff_cnt;

  logic present;
  logic bypass;
  logic pop;
  logic wr;
  logic overrun;

  ps2_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .mclk      (mclk),
    .reset_in  (reset_in),
    .ps2_clk   (PS2_Clk),
    .ps2_data  (PS2_Data),
    .data_sync (ps2_data_s),
    .fall      (ps2_fall)
  );

  // Frame decoder: start/data/parity/stop with an inactivity timeout.
  always_ff @(posedge mclk) begin
    if (reset_in) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      push_valid <= 1'b0;
      push_data  <= '0;
      err_req    <= 1'b0;
    end else begin
      push_valid <= 1'b0;
      err_req    <= 1'b0;
      if (state == IDLE) begin
        tmo_cnt <= '0;
        bitcnt  <= '0;
        if (ps2_fall && !ps2_data_s) state <= DATA;
      end else if (ps2_fall) begin
        tmo_cnt <= '0;
        case (state)
          DATA: begin
            shreg <= {ps2_data_s, shreg[FRAME_BITS-1:1]};
            if (bitcnt == 3'(FRAME_BITS - 1)) begin
              bitcnt <= '0;
              state  <= PARITY;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end
          PARITY: begin
            par_bit <= ps2_data_s;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (odd_parity_ok(shreg, par_bit) && ps2_data_s) begin
              push_valid <= 1'b1;
              push_data  <= shreg;
            end else begin
              err_req <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
        state   <= IDLE;
        tmo_cnt <= '0;
        bitcnt  <= '0;
        shreg   <= '0;
        err_req <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // A fresh byte bypasses the empty FIFO so it can be presented right away.
  always_comb begin
    present = !Scan_DAV && (holdoff_cnt == '0) && ((count != '0) || push_valid);
    bypass  = present && (count == '0);
    pop     = present && (count != '0);
    wr      = push_valid && !bypass && ((count != NW'(FIFO_DEPTH)) || pop);
    overrun = push_valid && !bypass && (count == NW'(FIFO_DEPTH)) && !pop;
  end

  // FIFO storage; contents only matter where count says they are valid.
  always_ff @(posedge mclk) begin
    if (wr) fifo_mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, presentation, holdoff and the merged error pulse.
  always_ff @(posedge mclk) begin
    if (reset_in) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      holdoff_cnt <= '0;
      Scan_DAV    <= 1'b0;
      Scan_Code   <= '0;
      Scan_Err    <= 1'b0;
    end else begin
      Scan_Err <= err_req | overrun;
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (DoRead && Scan_DAV) begin
        Scan_DAV    <= 1'b0;
        holdoff_cnt <= HW'(HOLDOFF);
      end else if (holdoff_cnt != '0) begin
        holdoff_cnt <= holdoff_cnt - 1'b1;
      end
      if (present) begin
        Scan_DAV  <= 1'b1;
        Scan_Code <= bypass ? push_data : fifo_mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: PS/2 frames are bit-banged on the inputs,
// outputs are sampled on the falling edge of mclk.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int HOLDOFF     = 4;
  localparam int TIMEOUT_CYC = 16384;

  logic       mclk = 1'b0;
  logic       reset_in = 1'b1;
  logic       PS2_Clk = 1'b1;
  logic       PS2_Data = 1'b1;
  logic       DoRead = 1'b0;
  logic       Scan_DAV;
  logic [7:0] Scan_Code;
  logic       Scan_Err;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int err_long = 0;
  logic err_prev = 1'b0;
  logic [7:0] exp_q[$];

  ps2_rx #(
    .FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT_CYC), .HOLDOFF(HOLDOFF)
  ) dut (
    .mclk(mclk), .reset_in(reset_in), .PS2_Clk(PS2_Clk), .PS2_Data(PS2_Data),
    .DoRead(DoRead), .Scan_DAV(Scan_DAV), .Scan_Code(Scan_Code), .Scan_Err(Scan_Err)
  );

  // clock / reset
  always #5 mclk = ~mclk;

  // error pulse monitor
  always @(negedge mclk) begin
    if (Scan_Err) err_cnt++;
    if (Scan_Err && err_prev) err_long++;
    err_prev = Scan_Err;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    PS2_Data = b;
    tick(8);
    if (glitch) begin
      PS2_Clk = 1'b0; tick(3); PS2_Clk = 1'b1;
    end
    tick(8);
    PS2_Clk = 1'b0; tick(20);
    PS2_Clk = 1'b1; tick(5);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input int glitch_bit);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i], i == glitch_bit);
    PS2_Data = 1'b1;
  endtask

  task automatic ack();
    DoRead = 1'b1; tick(1); DoRead = 1'b0; tick(HOLDOFF + 3);
  endtask

  task automatic test_reset();
    reset_in = 1'b1; tick(3); reset_in = 1'b0; tick(1);
    total++; if (Scan_DAV !== 1'b0) begin bad++; $display("FAIL reset_dav got=%b exp=0", Scan_DAV); end
    total++; if (Scan_Code !== 8'h00) begin bad++; $display("FAIL reset_code got=%h exp=00", Scan_Code); end
    total++; if (Scan_Err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", Scan_Err); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=IDLE", dut.state); end
  endtask

  task automatic test_good_byte();
    logic [10:0] f;
    int e0, w, lat;
    e0 = err_cnt;
    f = {1'b1, 1'b0, 8'h1C, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(f[i], 1'b0);
    PS2_Data = 1'b1; tick(16);
    PS2_Clk = 1'b0;
    w = 0;
    while (dut.ps2_fall !== 1'b1 && w < 40) begin tick(1); w++; end
    total++; if (w >= 40) begin bad++; $display("FAIL good_stop_fall got=none exp=fall"); end
    lat = 0;
    while (Scan_DAV !== 1'b1 && lat < 10) begin tick(1); lat++; end
    total++; if (lat != 2) begin bad++; $display("FAIL good_latency got=%0d exp=2", lat); end
    tick(20); PS2_Clk = 1'b1; tick(5);
    total++; if (Scan_DAV !== 1'b1) begin bad++; $display("FAIL good_dav got=%b exp=1", Scan_DAV); end
    total++; if (Scan_Code !== 8'h1C) begin bad++; $display("FAIL good_code got=%h exp=1c", Scan_Code); end
    total++; if (err_cnt != e0) begin bad++; $display("FAIL good_err got=%0d exp=0", err_cnt - e0); end
    ack();
    total++; if (Scan_DAV !== 1'b0) begin bad++; $display("FAIL ack_dav got=%b exp=0", Scan_DAV); end
    total++; if (Scan_Code !== 8'h1C) begin bad++; $display("FAIL ack_code_hold got=%h exp=1c", Scan_Code); end
  endtask

  task automatic test_parity_err();
    int e0;
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, -1); tick(5);
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL parity_err_cnt got=%0d exp=1", err_cnt - e0); end
    total++; if (Scan_DAV !== 1'b0) begin bad++; $display("FAIL parity_dav got=%b exp=0", Scan_DAV); end
    send_frame(8'h12, 1'b0, -1);
    total++; if (Scan_DAV !== 1'b1) begin bad++; $display("FAIL parity_next_dav got=%b exp=1", Scan_DAV); end
    total++; if (Scan_Code !== 8'h12) begin bad++; $display("FAIL parity_next_code got=%h exp=12", Scan_Code); end
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL parity_next_err got=%0d exp=1", err_cnt - e0); end
    ack();
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    int e0, w;
    e0 = err_cnt;
    d = 8'h1C;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(d[i], 1'b0);
    PS2_Data = 1'b1;
    w = 0;
    while (err_cnt == e0 && w < TIMEOUT_CYC + 200) begin tick(1); w++; end
    tick(3);
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL timeout_err got=%0d exp=1", err_cnt - e0); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL timeout_state got=%0d exp=IDLE", dut.state); end
    total++; if (Scan_DAV !== 1'b0) begin bad++; $display("FAIL timeout_dav got=%b exp=0", Scan_DAV); end
    send_frame(8'hF0, 1'b0, -1);
    total++; if (Scan_DAV !== 1'b1) begin bad++; $display("FAIL timeout_next_dav got=%b exp=1", Scan_DAV); end
    total++; if (Scan_Code !== 8'hF0) begin bad++; $display("FAIL timeout_next_code got=%h exp=f0", Scan_Code); end
    ack();
  endtask

  task automatic test_glitch();
    int e0;
    e0 = err_cnt;
    PS2_Data = 1'b0; tick(5);
    PS2_Clk = 1'b0; tick(3); PS2_Clk = 1'b1; tick(20);
    PS2_Data = 1'b1;
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL glitch_idle_state got=%0d exp=IDLE", dut.state); end
    send_frame(8'h75, 1'b0, 4);
    total++; if (Scan_DAV !== 1'b1) begin bad++; $display("FAIL glitch_dav got=%b exp=1", Scan_DAV); end
    total++; if (Scan_Code !== 8'h75) begin bad++; $display("FAIL glitch_code got=%h exp=75", Scan_Code); end
    total++; if (err_cnt != e0) begin bad++; $display("FAIL glitch_err got=%0d exp=0", err_cnt - e0); end
    ack();
  endtask

  task automatic test_overrun();
    logic [7:0] frames [6];
    logic [7:0] exp_b;
    int e0, cyc, last_rise, got;
    frames = '{8'hE0, 8'h75, 8'hF0, 8'h75, 8'h5A, 8'h29};
    e0 = err_cnt;
    for (int i = 0; i < 6; i++) send_frame(frames[i], 1'b0, -1);
    tick(5);
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL overrun_err got=%0d exp=1", err_cnt - e0); end
    total++; if (Scan_DAV !== 1'b1) begin bad++; $display("FAIL overrun_dav got=%b exp=1", Scan_DAV); end
    total++; if (Scan_Code !== 8'hE0) begin bad++; $display("FAIL overrun_first got=%h exp=e0", Scan_Code); end
    for (int i = 1; i < 5; i++) exp_q.push_back(frames[i]);
    DoRead = 1'b1;
    cyc = 0; last_rise = 0; got = 0;
    while (got < 4 && cyc < 300) begin
      tick(1); cyc++;
      if (Scan_DAV === 1'b1) begin
        exp_b = exp_q.pop_front();
        total++; if (Scan_Code !== exp_b) begin bad++; $display("FAIL drain_code got=%h exp=%h", Scan_Code, exp_b); end
        total++; if (cyc - last_rise < HOLDOFF + 1) begin bad++; $display("FAIL drain_spacing got=%0d exp>=%0d", cyc - last_rise, HOLDOFF + 1); end
        last_rise = cyc; got++;
      end
    end
    total++; if (got != 4) begin bad++; $display("FAIL drain_count got=%0d exp=4", got); end
    tick(20);
    total++; if (Scan_DAV !== 1'b0) begin bad++; $display("FAIL drain_extra got=%b exp=0", Scan_DAV); end
    DoRead = 1'b0;
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL drain_err got=%0d exp=1", err_cnt - e0); end
  endtask

  task automatic test_ignore_doread();
    DoRead = 1'b1; tick(3); DoRead = 1'b0; tick(2);
    total++; if (Scan_DAV !== 1'b0) begin bad++; $display("FAIL ignore_dav got=%b exp=0", Scan_DAV); end
    send_frame(8'h5A, 1'b0, -1);
    total++; if (Scan_DAV !== 1'b1) begin bad++; $display("FAIL ignore_next_dav got=%b exp=1", Scan_DAV); end
    total++; if (Scan_Code !== 8'h5A) begin bad++; $display("FAIL ignore_next_code got=%h exp=5a", Scan_Code); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    int e0;
    d = 8'h1C;
    e0 = err_cnt;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(d[i], 1'b0);
    PS2_Data = 1'b1;
    reset_in = 1'b1; tick(2); reset_in = 1'b0; tick(2);
    total++; if (Scan_DAV !== 1'b0) begin bad++; $display("FAIL midreset_dav got=%b exp=0", Scan_DAV); end
    total++; if (Scan_Code !== 8'h00) begin bad++; $display("FAIL midreset_code got=%h exp=00", Scan_Code); end
    total++; if (err_cnt != e0) begin bad++; $display("FAIL midreset_err got=%0d exp=0", err_cnt - e0); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL midreset_state got=%0d exp=IDLE", dut.state); end
    send_frame(8'h1C, 1'b0, -1);
    total++; if (Scan_DAV !== 1'b1) begin bad++; $display("FAIL midreset_next_dav got=%b exp=1", Scan_DAV); end
    total++; if (Scan_Code !== 8'h1C) begin bad++; $display("FAIL midreset_next_code got=%h exp=1c", Scan_Code); end
    ack();
  endtask

  initial begin
    test_reset();
    test_good_byte();
    test_parity_err();
    test_timeout();
    test_glitch();
    test_overrun();
    test_ignore_doread();
    test_reset_midframe();
    total++; if (err_long != 0) begin bad++; $display("FAIL err_pulse_width got=%0d exp=0", err_long); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
